bot_update_hub: RTL and testbench
=================================

Name: bot_update_hub

Overview:
- Parametrised successor to the single-channel bot-update handshake flip-flop.
- Accepts NCH asynchronous update indications from the video or rojobot domain, synchronizes them into the MIPS clock domain and holds a per-channel IO_BotUpdt_Sync-style pending flag until the CPU returns IO_INT_ACK.
- Adds features the single-channel version does not have:
  - per-channel enable mask;
  - level or toggle input mode;
  - saturating missed-update counters;
  - sticky acknowledge-timeout flags;
  - a lowest-index pending encoder for interrupt dispatch.

Parameters:
NCH, 4, number of update channels (1..16)
SYNC_STAGES, 2, synchronizer flops per channel (2..4)
TOGGLE_MODE, 0, 0 = event on rising edge of synchronized input; 1 = event on any edge
CNT_W, 8, width of each missed-update counter
TIMEOUT_CYC, 0, clk cycles a flag may stay pending before timeout is flagged; 0 disables timeout logic

Ports:
clk  in  1  MIPS-domain clock (50 MHz)
resetn  in  1  asynchronous active-low reset
upd_async  in  NCH  raw update indications from the foreign domain (level or toggle)
ch_en  in  NCH  channel enable mask, synchronous to clk
int_ack  in  NCH  per-channel acknowledge (IO_INT_ACK), sampled each clk edge
clr_stat  in  1  synchronous clear of all miss counters and timeout flags
upd_sync  out  NCH  per-channel pending flag (IO_BotUpdt_Sync), registered
irq  out  1  OR of upd_sync, combinational from registers
first_vld  out  1  at least one channel pending
first_idx  out  clog2(NCH) (minimum 1)  lowest pending channel index; 0 when none pending
miss_cnt  out  NCH*CNT_W  packed saturating counters, channel i at [i*CNT_W +: CNT_W]
timeout_flg  out  NCH  sticky per-channel ack-timeout flags

Behaviour:
- Reset (resetn low, asynchronous): all synchronizer flops, edge-detect flops, pending flags, counters, age counters and flags clear to 0; prime counter is set to SYNC_STAGES+1.
  - Outputs during reset: upd_sync = 0, irq = 0, first_vld = 0, first_idx = 0, miss_cnt = 0, timeout_flg = 0.
- Synchronizer: each channel has a SYNC_STAGES-deep flop chain (s) followed by one history flop (h).
  - Raw event: ev = s_last & ~h when TOGGLE_MODE = 0; ev = s_last ^ h when TOGGLE_MODE = 1.
- Priming: for SYNC_STAGES+1 cycles after reset release, h tracks s_last and ev is forced to 0. No spurious event is produced from a static high input.
- Latency: a stable input change registered by edge 1 sets upd_sync on edge SYNC_STAGES+2. With the default SYNC_STAGES = 2, that is 4 edges.
- The foreign domain must hold a level or toggle at least 2 clk periods. Use toggle mode for single-cycle 75 MHz pulses.
- Per-channel pending update, evaluated on each edge in priority order:
  1. ch_en = 0: pending cleared; ev ignored; no miss counted.
  2. ev and int_ack together: pending stays 1 (new event wins); no miss counted.
  3. int_ack only: pending cleared.
  4. ev while pending and no int_ack: pending stays 1; miss_cnt[i] increments, saturating at 2^CNT_W-1 (no wrap).
  5. ev while not pending: pending set.
- int_ack on a channel that is not pending has no effect.
- first_idx: priority encoder, lowest index wins. first_vld = |upd_sync.
- Timeout (TIMEOUT_CYC > 0): each channel has an age counter of width clog2(TIMEOUT_CYC+1).
  - The counter is 0 while not pending and increments each cycle while pending, saturating at TIMEOUT_CYC.
  - timeout_flg[i] sets on the edge the counter reaches TIMEOUT_CYC.
  - A re-set by a new event while pending does not restart the age counter.
  - When pending clears, the counter returns to 0; the flag stays set.
- Timeout disabled (TIMEOUT_CYC = 0): no age counters are generated; timeout_flg is tied to 0.
- clr_stat: zeroes all miss_cnt and timeout_flg on the next edge. If clr_stat coincides with an increment or a timeout, the clear wins. Pending flags are unaffected.
- Reset mid-handshake: pending is lost, and priming repeats after release.

Test Plan:
1. NCH=4, TOGGLE_MODE=0, all ch_en=1; raise upd_async[2] at edge 10 -> upd_sync=4'b0100 after edge 13, irq=1, first_idx=2; int_ack[2] high 1 cycle at edge 20 -> upd_sync=0 at edge 21.
2. Hold upd_async[0]=1 through reset release -> no event ever; drop to 0 then raise -> exactly one event, after a 4-edge latency.
3. TOGGLE_MODE=1; toggle upd_async[1] three times, 5 cycles apart, with no ack -> upd_sync[1]=1 and miss_cnt[1]=2; ev coincident with int_ack -> pending stays 1, miss_cnt unchanged.
4. CNT_W=2; generate 6 events on ch3 with no ack -> miss_cnt[3] saturates at 3; clr_stat -> 0 next edge.
5. TIMEOUT_CYC=10; event on ch1 with no ack -> timeout_flg[1]=1 exactly 10 cycles after upd_sync[1] rises; ack at cycle 9 on a second run -> flag stays 0.
6. ch0 and ch3 pending -> first_idx=0; clear ch_en[0] -> upd_sync[0]=0 next edge, first_idx=3; events on masked ch0 -> no pending and no miss.

Source files
------------

// File: rtl/bot_update_hub.sv
// Multi-channel bot-update handshake hub: synchronizes foreign-domain update
// indications, holds per-channel pending flags until acknowledged, tracks misses/timeouts.
module bot_update_hub #(
    parameter int NCH         = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TOGGLE_MODE = 0,
    parameter int CNT_W       = 8,
    parameter int TIMEOUT_CYC = 0,
    localparam int IW         = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [NCH-1:0]       upd_async,
    input  logic [NCH-1:0]       ch_en,
    input  logic [NCH-1:0]       int_ack,
    input  logic                 clr_stat,
    output logic [NCH-1:0]       upd_sync,
    output logic                 irq,
    output logic                 first_vld,
    output logic [IW-1:0]        first_idx,
    output logic [NCH*CNT_W-1:0] miss_cnt,
    output logic [NCH-1:0]       timeout_flg
);

    localparam logic [2:0] PRIME_INIT = 3'(SYNC_STAGES + 1);

    logic [NCH-1:0][SYNC_STAGES-1:0] sync_r;
    logic [NCH-1:0]                  hist_r;
    logic [NCH-1:0]                  ev_r;
    logic [2:0]                      prime_r;
    logic [NCH-1:0]                  last_s;
    logic [NCH-1:0]                  raw_ev_s;
    logic [NCH-1:0]                  pend_r;
    logic [NCH-1:0]                  pend_nxt_s;
    logic [NCH-1:0]                  inc_s;
    logic [NCH-1:0][CNT_W-1:0]       miss_r;
    logic [IW-1:0]                   idx_s;

    // Raw edge detection on the last synchronizer stage against the history flop
    always_comb begin
        last_s   = '0;
        raw_ev_s = '0;
        for (int i = 0; i < NCH; i++) begin
            last_s[i] = sync_r[i][SYNC_STAGES-1];
        end
        if (TOGGLE_MODE != 0) begin
            raw_ev_s = last_s ^ hist_r;
        end else begin
            raw_ev_s = last_s & ~hist_r;
        end
    end

    // Synchronizer chains, history flops and registered event; events masked while priming
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_r  <= '0;
            hist_r  <= '0;
            ev_r    <= '0;
            prime_r <= PRIME_INIT;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                sync_r[i] <= {sync_r[i][SYNC_STAGES-2:0], upd_async[i]};
            end
            hist_r <= last_s;
            ev_r   <= (prime_r == 3'd0) ? raw_ev_s : '0;
            if (prime_r != 3'd0) begin
                prime_r <= prime_r - 3'd1;
            end
        end
    end

    // Pending-flag priority resolution and miss detection
    always_comb begin
        pend_nxt_s = pend_r;
        inc_s      = '0;
        for (int i = 0; i < NCH; i++) begin
            if (!ch_en[i]) begin
                pend_nxt_s[i] = 1'b0;
            end else if (ev_r[i] && int_ack[i]) begin
                pend_nxt_s[i] = 1'b1;
            end else if (int_ack[i]) begin
                pend_nxt_s[i] = 1'b0;
            end else if (ev_r[i] && pend_r[i]) begin
                inc_s[i] = 1'b1;
            end else if (ev_r[i]) begin
                pend_nxt_s[i] = 1'b1;
            end else begin
                pend_nxt_s[i] = pend_r[i];
            end
        end
    end

    // Pending flags and saturating miss counters; clr_stat beats an increment
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pend_r <= '0;
            miss_r <= '0;
        end else begin
            pend_r <= pend_nxt_s;
            for (int i = 0; i < NCH; i++) begin
                if (clr_stat) begin
                    miss_r[i] <= '0;
                end else if (inc_s[i] && (miss_r[i] != {CNT_W{1'b1}})) begin
                    miss_r[i] <= miss_r[i] + CNT_W'(1);
                end
            end
        end
    end

    generate
        if (TIMEOUT_CYC > 0) begin : g_to
            localparam int AW = $clog2(TIMEOUT_CYC + 1);
            logic [NCH-1:0][AW-1:0] age_r;
            logic [NCH-1:0]         hit_s;
            logic [NCH-1:0]         tflg_r;

            // A channel times out on the edge its age reaches the limit while still pending
            always_comb begin
                hit_s = '0;
                for (int i = 0; i < NCH; i++) begin
                    if (pend_r[i] && pend_nxt_s[i] && (age_r[i] == AW'(TIMEOUT_CYC - 1))) begin
                        hit_s[i] = 1'b1;
                    end else begin
                        hit_s[i] = 1'b0;
                    end
                end
            end

            // Age counters run only across continuous pending; flags are sticky until clr_stat
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    age_r  <= '0;
                    tflg_r <= '0;
                end else begin
                    for (int i = 0; i < NCH; i++) begin
                        if (pend_r[i] && pend_nxt_s[i]) begin
                            if (age_r[i] != AW'(TIMEOUT_CYC)) begin
                                age_r[i] <= age_r[i] + AW'(1);
                            end
                        end else begin
                            age_r[i] <= '0;
                        end
                    end
                    tflg_r <= clr_stat ? '0 : (tflg_r | hit_s);
                end
            end

            assign timeout_flg = tflg_r;
        end else begin : g_no_to
            assign timeout_flg = '0;
        end
    endgenerate

    // Lowest-index pending channel wins dispatch
    always_comb begin
        idx_s = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (pend_r[i]) begin
                idx_s = IW'(i);
            end else begin
                idx_s = idx_s;
            end
        end
    end

    assign upd_sync  = pend_r;
    assign irq       = |pend_r;
    assign first_vld = |pend_r;
    assign first_idx = idx_s;
    assign miss_cnt  = miss_r;

endmodule

// File: tb/tb_bot_update_hub.sv
// Randomized bench for bot_update_hub: a level-mode instance with timeout and a
// toggle-mode instance, both checked every cycle against an event-level reference model.
module tb_bot_update_hub;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [3:0]  upd_async = 4'd0;
    logic [3:0]  ch_en = 4'hF;
    logic [3:0]  int_ack = 4'd0;
    logic        clr_stat = 1'b0;

    logic [3:0]  us_a, tf_a, us_b, tf_b;
    logic        irq_a, fv_a, irq_b, fv_b;
    logic [1:0]  fi_a, fi_b;
    logic [7:0]  mc_a;
    logic [11:0] mc_b;

    int n_checks = 0;
    int n_err = 0;

    // reference model state: [instance][channel]
    int m_pend[2][4];
    int m_miss[2][4];
    int m_flag[2][4];
    int m_start[2][4];
    int n_edge;
    logic [3:0] in_q[$];

    bot_update_hub #(.NCH(4), .SYNC_STAGES(2), .TOGGLE_MODE(0), .CNT_W(2), .TIMEOUT_CYC(10)) dut_a (
        .clk(clk), .resetn(resetn), .upd_async(upd_async), .ch_en(ch_en), .int_ack(int_ack),
        .clr_stat(clr_stat), .upd_sync(us_a), .irq(irq_a), .first_vld(fv_a), .first_idx(fi_a),
        .miss_cnt(mc_a), .timeout_flg(tf_a));

    bot_update_hub #(.NCH(4), .SYNC_STAGES(2), .TOGGLE_MODE(1), .CNT_W(3), .TIMEOUT_CYC(0)) dut_b (
        .clk(clk), .resetn(resetn), .upd_async(upd_async), .ch_en(ch_en), .int_ack(int_ack),
        .clr_stat(clr_stat), .upd_sync(us_b), .irq(irq_b), .first_vld(fv_b), .first_idx(fi_b),
        .miss_cnt(mc_b), .timeout_flg(tf_b));

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        n_edge = 0;
        in_q.delete();
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < 4; c++) begin
                m_pend[k][c] = 0; m_miss[k][c] = 0; m_flag[k][c] = 0; m_start[k][c] = 0;
            end
        end
    endtask

    // One clock edge: an input sampled at edge m acts on pending at edge m+3
    task automatic model_step();
        int ev, was, maxc;
        logic a, b;
        n_edge++;
        in_q.push_back(upd_async);
        for (int k = 0; k < 2; k++) begin
            maxc = (k == 0) ? 3 : 7;
            for (int c = 0; c < 4; c++) begin
                ev = 0;
                if (n_edge >= 5) begin
                    a = in_q[n_edge - 4][c];
                    b = in_q[n_edge - 5][c];
                    ev = (k == 0) ? int'(a && !b) : int'(a != b);
                end
                was = m_pend[k][c];
                if (!ch_en[c]) m_pend[k][c] = 0;
                else if (ev != 0 && int_ack[c]) m_pend[k][c] = 1;
                else if (int_ack[c]) m_pend[k][c] = 0;
                else if (ev != 0 && was != 0) begin
                    if (!clr_stat && m_miss[k][c] < maxc) m_miss[k][c]++;
                end
                else if (ev != 0) m_pend[k][c] = 1;
                if (clr_stat) m_miss[k][c] = 0;
                if (k == 0) begin
                    if (was == 0 && m_pend[k][c] != 0) m_start[k][c] = n_edge;
                    if (clr_stat) m_flag[k][c] = 0;
                    else if (was != 0 && m_pend[k][c] != 0 && n_edge - m_start[k][c] == 10)
                        m_flag[k][c] = 1;
                end
            end
        end
    endtask

    task automatic compare_all();
        logic [3:0] e_us, e_tf;
        logic [11:0] e_mc;
        int e_idx;
        string nm;
        for (int k = 0; k < 2; k++) begin
            e_us = '0; e_tf = '0; e_mc = '0; e_idx = 0;
            for (int c = 3; c >= 0; c--) begin
                e_us[c] = (m_pend[k][c] != 0);
                e_tf[c] = (m_flag[k][c] != 0);
                if (m_pend[k][c] != 0) e_idx = c;
            end
            for (int c = 0; c < 4; c++) begin
                if (k == 0) e_mc[c*2 +: 2] = 2'(m_miss[k][c]);
                else        e_mc[c*3 +: 3] = 3'(m_miss[k][c]);
            end
            nm = (k == 0) ? "a" : "b";
            chk({nm, ".upd_sync"},    (k == 0) ? 32'(us_a) : 32'(us_b), 32'(e_us));
            chk({nm, ".irq"},         (k == 0) ? 32'(irq_a) : 32'(irq_b), 32'(|e_us));
            chk({nm, ".first_vld"},   (k == 0) ? 32'(fv_a) : 32'(fv_b), 32'(|e_us));
            chk({nm, ".first_idx"},   (k == 0) ? 32'(fi_a) : 32'(fi_b), 32'(e_idx));
            chk({nm, ".miss_cnt"},    (k == 0) ? 32'(mc_a) : 32'(mc_b), 32'(e_mc));
            chk({nm, ".timeout_flg"}, (k == 0) ? 32'(tf_a) : 32'(tf_b), 32'(e_tf));
        end
    endtask

    task automatic do_reset(input logic [3:0] hold_in);
        #1;
        resetn = 1'b0;
        upd_async = hold_in;
        int_ack = '0;
        clr_stat = 1'b0;
        ch_en = 4'hF;
        model_clear();
        #1;
        compare_all();
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    initial begin
        int ack_div, phase;
        model_clear();
        @(posedge clk);
        do_reset(4'b0001);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc == 1000 || cyc == 2000) begin
                do_reset(4'($urandom_range(0, 15)));
            end
            phase = (cyc / 150) % 4;
            ack_div = (phase == 0) ? 3 : (phase == 1) ? 20 : 0;
            for (int c = 0; c < 4; c++) begin
                if ($urandom_range(0, 3) == 0) upd_async[c] = ~upd_async[c];
                int_ack[c] = (ack_div != 0) && ($urandom_range(0, ack_div - 1) == 0);
                ch_en[c]   = (phase == 3) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 63) != 0);
            end
            clr_stat = ($urandom_range(0, 49) == 0);
            @(posedge clk);
            model_step();
            #1;
            compare_all();
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
